// File: rtl/debounce_pkg.sv
// Shared constants for the switch debouncer: FSM encoding,
// default qualification length and counter width helper.
package debounce_pkg;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_CHECK = 1'b1;

  localparam int STABLE_CYCLES_DEF = 50000;

  function automatic int cnt_width(input int stable);
    return $clog2(stable + 1);
  endfunction

endpackage

// File: rtl/debounce_ch.sv
// One debounce channel: 2-flop synchroniser, IDLE/CHECK FSM,
// qualification counter; rise/fall pulses with DEBOUNCE_EDGE_EN.
module debounce_ch
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic db,
  output logic busy
`ifdef DEBOUNCE_EDGE_EN
  ,
  output logic rise,
  output logic fall
`endif
);

  localparam int CNT_W = cnt_width(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

  logic             s1_q;
  logic             s2_q;
  logic             state_q;
  logic             state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             db_q;
  logic             db_d;
  logic             busy_q;
  logic             busy_d;

  // raw is asynchronous; only s2_q is safe to use
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= raw;
      s2_q <= s1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      db_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      db_q    <= db_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    db_d    = db_q;
    unique case (state_q)
      ST_IDLE: begin
        if (s2_q != db_q) begin
          state_d = ST_CHECK;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d   = '0;
        end
      end
      ST_CHECK: begin
        if (s2_q == db_q) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          db_d    = s2_q;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
    endcase
  end

  always_comb begin
    busy_d = (state_d == ST_CHECK);
  end

  assign db   = db_q;
  assign busy = busy_q;

`ifdef DEBOUNCE_EDGE_EN
  logic rise_q;
  logic fall_q;

  // pulses line up with the first cycle db shows its new level
  always_ff @(posedge clk) begin
    if (rst) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= db_d & ~db_q;
      fall_q <= ~db_d & db_q;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;
`endif

endmodule

// File: rtl/switch_debouncer.sv
// Multi-channel switch debouncer feeding the gate block (db[0]->a, db[1]->b).
// Optional rise/fall pulse outputs when DEBOUNCE_EDGE_EN is defined.
module switch_debouncer
  import debounce_pkg::*;
#(
  parameter int NUM_CH        = 2,
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] raw,
  output logic [NUM_CH-1:0] db,
  output logic [NUM_CH-1:0] busy
`ifdef DEBOUNCE_EDGE_EN
  ,
  output logic [NUM_CH-1:0] rise,
  output logic [NUM_CH-1:0] fall
`endif
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    debounce_ch #(
      .STABLE_CYCLES(STABLE_CYCLES)
    ) u_ch (
      .clk (clk),
      .rst (rst),
      .raw (raw[i]),
      .db  (db[i]),
      .busy(busy[i])
`ifdef DEBOUNCE_EDGE_EN
      ,
      .rise(rise[i]),
      .fall(fall[i])
`endif
    );
  end

endmodule

// File: tb/tb_switch_debouncer.sv
// Scoreboard bench for switch_debouncer against a run-length
// reference model; checks rise/fall when DEBOUNCE_EDGE_EN is defined.
module tb_switch_debouncer;

  localparam int NCH = 2;
  localparam int S   = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [NCH-1:0] raw = '0;
  logic [NCH-1:0] db;
  logic [NCH-1:0] busy;
`ifdef DEBOUNCE_EDGE_EN
  logic [NCH-1:0] rise;
  logic [NCH-1:0] fall;
`endif

  always #5 clk = ~clk;

  switch_debouncer #(
    .NUM_CH(NCH),
    .STABLE_CYCLES(S)
  ) dut (
    .clk (clk),
    .rst (rst),
    .raw (raw),
    .db  (db),
    .busy(busy)
`ifdef DEBOUNCE_EDGE_EN
    ,
    .rise(rise),
    .fall(fall)
`endif
  );

  typedef struct packed {
    logic [NCH-1:0] db;
    logic [NCH-1:0] busy;
    logic [NCH-1:0] rise;
    logic [NCH-1:0] fall;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  bit   done     = 1'b0;

  // reference: db flips once S+1 consecutive synchronised
  // samples (raw delayed two edges) disagree with it
  logic [NCH-1:0] m_db = '0;
  logic [NCH-1:0] m_rise = '0;
  logic [NCH-1:0] m_fall = '0;
  logic [NCH-1:0] dly0 = '0;
  logic [NCH-1:0] dly1 = '0;
  int             run[NCH];

  task automatic step(input logic r, input logic [NCH-1:0] v);
    exp_t e;
    @(negedge clk);
    rst = r;
    raw = v;
    @(posedge clk);
    m_rise = '0;
    m_fall = '0;
    if (r) begin
      dly0 = '0;
      dly1 = '0;
      m_db = '0;
      for (int c = 0; c < NCH; c++) run[c] = 0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        logic smp;
        smp = dly1[c];
        dly1[c] = dly0[c];
        dly0[c] = v[c];
        if (smp !== m_db[c]) begin
          run[c]++;
          if (run[c] == S + 1) begin
            m_db[c] = ~m_db[c];
            if (m_db[c]) m_rise[c] = 1'b1;
            else         m_fall[c] = 1'b1;
            run[c] = 0;
          end
        end else begin
          run[c] = 0;
        end
      end
    end
    e.db   = m_db;
    e.rise = m_rise;
    e.fall = m_fall;
    for (int c = 0; c < NCH; c++) e.busy[c] = (run[c] != 0);
    q.push_back(e);
  endtask

  task automatic hold(input logic [NCH-1:0] v, input int n);
    for (int i = 0; i < n; i++) step(1'b0, v);
  endtask

  task automatic chk(input string nm, input logic [NCH-1:0] a,
                     input logic [NCH-1:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s t=%0t actual=%b required=%b", nm, $time, a, e);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (done) break;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("db", db, e.db);
        chk("busy", busy, e.busy);
`ifdef DEBOUNCE_EDGE_EN
        chk("rise", rise, e.rise);
        chk("fall", fall, e.fall);
`endif
      end
    end
  end

  initial begin : stim
    int hl[NCH];
    logic [NCH-1:0] rv;
    for (int c = 0; c < NCH; c++) run[c] = 0;
    // reset with raw held high, then release
    for (int i = 0; i < 3; i++) step(1'b1, 2'b11);
    hold(2'b11, 12);
    hold(2'b00, 12);
    // clean step on channel 0
    hold(2'b01, 12);
    hold(2'b00, 12);
    // bounce then settle high
    for (int i = 0; i < 8; i++) step(1'b0, (i % 2 == 0) ? 2'b01 : 2'b00);
    hold(2'b01, 12);
    // short glitch on channel 1
    hold(2'b11, 3);
    hold(2'b01, 12);
    // reset while channel 0 counts
    hold(2'b00, 12);
    hold(2'b01, 4);
    step(1'b1, 2'b01);
    hold(2'b01, 12);
    // up then down for edge pulses
    hold(2'b00, 12);
    hold(2'b01, 12);
    hold(2'b00, 12);
    // randomised hold lengths around the threshold
    rv = '0;
    for (int c = 0; c < NCH; c++) hl[c] = 1;
    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < NCH; c++) begin
        hl[c]--;
        if (hl[c] <= 0) begin
          rv[c] = ~rv[c];
          hl[c] = int'($urandom_range(1, 2 * S + 4));
        end
      end
      step(($urandom_range(0, 199) == 0), rv);
    end
    hold(rv, 12);
    @(negedge clk);
    done = 1'b1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
